// File: rtl/lsu_mem_ctrl_if.sv
// Datapath-side request/response and memory-side req/ack bus of the LSU.
// slave = the LSU controller; master = datapath plus data memory.
interface lsu_mem_ctrl_if;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_rdata;
  logic        lsu_done;
  logic        lsu_fault;
  logic        lsu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  lsu_req, lsu_we, lsu_funct3, lsu_addr, lsu_wdata, mem_ack, mem_rdata,
    output lsu_rdata, lsu_done, lsu_fault, lsu_stall,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output lsu_req, lsu_we, lsu_funct3, lsu_addr, lsu_wdata, mem_ack, mem_rdata,
    input  lsu_rdata, lsu_done, lsu_fault, lsu_stall,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: byte-addressed datapath access -> word req/ack memory beats.
// MISALIGN_SPLIT_EN: when defined, misaligned accesses run as one or two beats instead of faulting.
module lsu_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic          clk,
  input  logic          rst,
  lsu_mem_ctrl_if.slave bus
);

`ifdef MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_DONE, S_BEAT1} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_DONE} state_t;
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_off;
  logic [1:0]       r_size;
  logic             r_uns;
`ifdef MISALIGN_SPLIT_EN
  logic             r_split;
  logic [3:0]       r_be1;
  logic [31:0]      r_wdata1;
  logic [31:0]      r_rd0;
`endif

  logic [1:0]  w_off;
  logic [1:0]  w_size;
  logic        w_uns;
  logic        w_legal;
  logic        w_misal;
  logic        w_reject;
  logic        w_tmo;
  logic [3:0]  w_be_base;
  logic [3:0]  w_be0;
  logic [31:0] w_wrep;
`ifdef MISALIGN_SPLIT_EN
  logic [7:0]  w_be8;
  logic [3:0]  w_be1;
  logic [63:0] w_wsh;
  logic        w_cross;
`endif

  // Shift the (possibly two-word) raw read so the addressed byte sits in lane 0, then extend.
  function automatic logic [31:0] f_extract(input logic [63:0] raw, input logic [1:0] off,
                                            input logic [1:0] size, input logic uns);
    logic [31:0] w;
    w = 32'(raw >> {off, 3'b000});
    case (size)
      2'd0:    f_extract = uns ? {24'b0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'd1:    f_extract = uns ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: f_extract = w;
    endcase
  endfunction

  always_comb begin
    w_off   = bus.lsu_addr[1:0];
    w_size  = bus.lsu_funct3[1:0];
    w_uns   = bus.lsu_funct3[2];
    w_legal = 1'b0;
    case (bus.lsu_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~bus.lsu_we;
      default:                w_legal = 1'b0;
    endcase
    w_misal = ((w_size == 2'd1) && w_off[0]) || ((w_size == 2'd2) && (w_off != 2'd0));
    case (w_size)
      2'd0:    begin w_be_base = 4'b0001; w_wrep = {4{bus.lsu_wdata[7:0]}};  end
      2'd1:    begin w_be_base = 4'b0011; w_wrep = {2{bus.lsu_wdata[15:0]}}; end
      default: begin w_be_base = 4'b1111; w_wrep = bus.lsu_wdata;           end
    endcase
`ifdef MISALIGN_SPLIT_EN
    w_be8    = {4'b0000, w_be_base} << w_off;
    w_be0    = w_be8[3:0];
    w_be1    = w_be8[7:4];
    w_cross  = |w_be8[7:4];
    w_wsh    = {32'b0, bus.lsu_wdata} << {w_off, 3'b000};
    w_reject = ~w_legal;
`else
    w_be0    = w_be_base << w_off;
    w_reject = ~w_legal | w_misal;
`endif
  end

  assign w_tmo         = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.lsu_stall = bus.lsu_req & ~bus.lsu_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_off         <= '0;
      r_size        <= '0;
      r_uns         <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      r_split       <= 1'b0;
      r_be1         <= '0;
      r_wdata1      <= '0;
      r_rd0         <= '0;
`endif
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      bus.lsu_rdata <= '0;
      bus.lsu_done  <= 1'b0;
      bus.lsu_fault <= 1'b0;
    end else begin
      bus.lsu_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.lsu_req) begin
          r_off         <= w_off;
          r_size        <= w_size;
          r_uns         <= w_uns;
          r_cnt         <= '0;
          bus.lsu_rdata <= '0;
          bus.lsu_fault <= 1'b0;
          bus.mem_we    <= bus.lsu_we;
          bus.mem_addr  <= bus.lsu_addr[31:2];
`ifdef MISALIGN_SPLIT_EN
          r_split       <= w_cross;
          r_be1         <= w_be1;
          r_wdata1      <= w_wsh[63:32];
          // Replicated data only lines up with the lanes when the access is aligned.
          bus.mem_wdata <= w_misal ? w_wsh[31:0] : w_wrep;
`else
          bus.mem_wdata <= w_wrep;
`endif
          if (w_reject) begin
            bus.lsu_fault <= 1'b1;
            bus.lsu_done  <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            bus.mem_req <= 1'b1;
            bus.mem_be  <= w_be0;
            r_state     <= S_BEAT0;
          end
        end
        S_BEAT0: if (bus.mem_ack) begin
`ifdef MISALIGN_SPLIT_EN
          // Second beat follows back-to-back: req stays up with the next word's address.
          if (r_split) begin
            r_rd0         <= bus.mem_rdata;
            bus.mem_addr  <= bus.mem_addr + 30'd1;
            bus.mem_be    <= r_be1;
            bus.mem_wdata <= r_wdata1;
            r_cnt         <= '0;
            r_state       <= S_BEAT1;
          end else
`endif
          begin
            bus.mem_req   <= 1'b0;
            bus.lsu_rdata <= bus.mem_we ? 32'b0 :
                             f_extract({32'b0, bus.mem_rdata}, r_off, r_size, r_uns);
            bus.lsu_done  <= 1'b1;
            r_state       <= S_DONE;
          end
        end else if (w_tmo) begin
          bus.mem_req   <= 1'b0;
          bus.lsu_fault <= 1'b1;
          bus.lsu_done  <= 1'b1;
          r_state       <= S_DONE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
`ifdef MISALIGN_SPLIT_EN
        S_BEAT1: if (bus.mem_ack) begin
          bus.mem_req   <= 1'b0;
          bus.lsu_rdata <= bus.mem_we ? 32'b0 :
                           f_extract({bus.mem_rdata, r_rd0}, r_off, r_size, r_uns);
          bus.lsu_done  <= 1'b1;
          r_state       <= S_DONE;
        end else if (w_tmo) begin
          bus.mem_req   <= 1'b0;
          bus.lsu_fault <= 1'b1;
          bus.lsu_done  <= 1'b1;
          r_state       <= S_DONE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
